// File: rtl/bank_dispatch_pq.sv
`timescale 1ns/1ps
// bank_dispatch_pq: buffers arriving customers in a VIP FIFO and a normal FIFO and
// dispatches one per cycle to the lowest-index idle service counter, which then counts
// its service time down to zero.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_num/in_time/in_vip   arrival strobe and payload (in_time==0 ignored)
//   num_bus, rem_bus    per-counter customer number / remaining time, counter i at [i*DT_SZ+:DT_SZ]
//   busy, done          per-counter busy flag and one-cycle finish pulse
//   nq_cnt, vq_cnt      normal / VIP FIFO occupancy
//   drop_cnt            saturating count of arrivals refused by a full FIFO
//   qdbg                normal FIFO contents {time,num}, head in slot 0, empty slots zero
module bank_dispatch_pq #(
    parameter int unsigned DT_SZ  = 4,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned VDEPTH = 2,
    parameter int unsigned PTR_W  = 2,
    parameter int unsigned CNTER  = 3,
    parameter int unsigned DROP_W = 8,
    parameter int unsigned VIP_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DT_SZ-1:0]           in_num,
    input  logic [DT_SZ-1:0]           in_time,
    input  logic                       in_vip,
    output logic [CNTER*DT_SZ-1:0]     num_bus,
    output logic [CNTER*DT_SZ-1:0]     rem_bus,
    output logic [CNTER-1:0]           busy,
    output logic [CNTER-1:0]           done,
    output logic [PTR_W-1:0]           nq_cnt,
    output logic [PTR_W-1:0]           vq_cnt,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic [DEPTH*2*DT_SZ-1:0]   qdbg
);

    logic [DT_SZ-1:0]         num_q [CNTER];
    logic [DT_SZ-1:0]         num_d [CNTER];
    logic [DT_SZ-1:0]         rem_q [CNTER];
    logic [DT_SZ-1:0]         rem_d [CNTER];
    logic [CNTER-1:0]         busy_q, busy_d, done_q, done_d;
    logic [DT_SZ-1:0]         nf_num_q [DEPTH];
    logic [DT_SZ-1:0]         nf_num_d [DEPTH];
    logic [DT_SZ-1:0]         nf_time_q [DEPTH];
    logic [DT_SZ-1:0]         nf_time_d [DEPTH];
    logic [DT_SZ-1:0]         vf_num_q [VDEPTH];
    logic [DT_SZ-1:0]         vf_num_d [VDEPTH];
    logic [DT_SZ-1:0]         vf_time_q [VDEPTH];
    logic [DT_SZ-1:0]         vf_time_d [VDEPTH];
    logic [PTR_W-1:0]         nf_head_q, nf_head_d, nf_cnt_q, nf_cnt_d;
    logic [PTR_W-1:0]         vf_head_q, vf_head_d, vf_cnt_q, vf_cnt_d;
    logic [DROP_W-1:0]        drop_q, drop_d;
    logic [DEPTH*2*DT_SZ-1:0] qdbg_q, qdbg_d;

    // Next-state: countdown, dispatch selection, FIFO push/pop, drop counting.
    always_comb begin
        logic             found, arr_ok, arr_vip, pop_v, pop_n, bypass, disp;
        logic             full_v, full_n, push_v, push_n, vpush_ok, npush_ok;
        logic [DT_SZ-1:0] vh_num, vh_time, nh_num, nh_time, ld_num, ld_time;
        int               free_idx, vtail, ntail, k;

        for (int i = 0; i < CNTER; i++) begin
            num_d[i] = num_q[i];
            rem_d[i] = rem_q[i];
        end
        for (int s = 0; s < DEPTH; s++) begin
            nf_num_d[s]  = nf_num_q[s];
            nf_time_d[s] = nf_time_q[s];
        end
        for (int s = 0; s < VDEPTH; s++) begin
            vf_num_d[s]  = vf_num_q[s];
            vf_time_d[s] = vf_time_q[s];
        end
        nf_head_d = nf_head_q;
        nf_cnt_d  = nf_cnt_q;
        vf_head_d = vf_head_q;
        vf_cnt_d  = vf_cnt_q;
        drop_d    = drop_q;
        done_d    = '0;
        busy_d    = '0;
        qdbg_d    = '0;
        found     = 1'b0;
        free_idx  = 0;
        vh_num    = '0;
        vh_time   = '0;
        nh_num    = '0;
        nh_time   = '0;
        k         = 0;

        // Countdown; a counter reaching zero clears its number and pulses done.
        for (int i = 0; i < CNTER; i++) begin
            if (rem_q[i] == DT_SZ'(1)) begin
                rem_d[i]  = '0;
                num_d[i]  = '0;
                done_d[i] = 1'b1;
            end else if (rem_q[i] != '0) begin
                rem_d[i] = rem_q[i] - DT_SZ'(1);
            end
        end

        // Free is judged on the pre-edge value so a just-finished counter waits a cycle.
        for (int i = 0; i < CNTER; i++) begin
            if (!found && rem_q[i] == '0) begin
                found    = 1'b1;
                free_idx = i;
            end
        end

        for (int s = 0; s < VDEPTH; s++) begin
            if (PTR_W'(s) == vf_head_q) begin
                vh_num  = vf_num_q[s];
                vh_time = vf_time_q[s];
            end
        end
        for (int s = 0; s < DEPTH; s++) begin
            if (PTR_W'(s) == nf_head_q) begin
                nh_num  = nf_num_q[s];
                nh_time = nf_time_q[s];
            end
        end

        arr_ok  = in_valid && (in_time != '0);
        arr_vip = in_vip && (VIP_EN != 0);
        pop_v   = found && (vf_cnt_q != '0);
        pop_n   = found && (vf_cnt_q == '0) && (nf_cnt_q != '0);
        bypass  = found && (vf_cnt_q == '0) && (nf_cnt_q == '0) && arr_ok;
        disp    = pop_v || pop_n || bypass;
        ld_num  = pop_v ? vh_num  : (pop_n ? nh_num  : in_num);
        ld_time = pop_v ? vh_time : (pop_n ? nh_time : in_time);

        for (int i = 0; i < CNTER; i++) begin
            if (disp && i == free_idx) begin
                num_d[i] = ld_num;
                rem_d[i] = ld_time;
            end
            busy_d[i] = (rem_d[i] != '0);
        end

        // Fullness uses pre-edge occupancy, so a same-edge pop does not make room.
        full_v   = (vf_cnt_q == PTR_W'(VDEPTH));
        full_n   = (nf_cnt_q == PTR_W'(DEPTH));
        push_v   = arr_ok && !bypass && arr_vip;
        push_n   = arr_ok && !bypass && !arr_vip;
        vpush_ok = push_v && !full_v;
        npush_ok = push_n && !full_n;

        if (((push_v && full_v) || (push_n && full_n)) && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + DROP_W'(1);
        end

        // VIP FIFO: tail slot is head+count modulo depth.
        vtail = int'(vf_head_q) + int'(vf_cnt_q);
        if (vtail >= int'(VDEPTH)) vtail = vtail - int'(VDEPTH);
        for (int s = 0; s < VDEPTH; s++) begin
            if (vpush_ok && s == vtail) begin
                vf_num_d[s]  = in_num;
                vf_time_d[s] = in_time;
            end
        end
        if (pop_v) vf_head_d = (vf_head_q == PTR_W'(VDEPTH - 1)) ? '0 : vf_head_q + PTR_W'(1);
        case ({vpush_ok, pop_v})
            2'b10:   vf_cnt_d = vf_cnt_q + PTR_W'(1);
            2'b01:   vf_cnt_d = vf_cnt_q - PTR_W'(1);
            default: vf_cnt_d = vf_cnt_q;
        endcase

        // Normal FIFO, same scheme.
        ntail = int'(nf_head_q) + int'(nf_cnt_q);
        if (ntail >= int'(DEPTH)) ntail = ntail - int'(DEPTH);
        for (int s = 0; s < DEPTH; s++) begin
            if (npush_ok && s == ntail) begin
                nf_num_d[s]  = in_num;
                nf_time_d[s] = in_time;
            end
        end
        if (pop_n) nf_head_d = (nf_head_q == PTR_W'(DEPTH - 1)) ? '0 : nf_head_q + PTR_W'(1);
        case ({npush_ok, pop_n})
            2'b10:   nf_cnt_d = nf_cnt_q + PTR_W'(1);
            2'b01:   nf_cnt_d = nf_cnt_q - PTR_W'(1);
            default: nf_cnt_d = nf_cnt_q;
        endcase

        // Debug view of the next normal FIFO state, rotated so the head lands in slot 0.
        for (int j = 0; j < DEPTH; j++) begin
            k = int'(nf_head_d) + j;
            if (k >= int'(DEPTH)) k = k - int'(DEPTH);
            for (int s = 0; s < DEPTH; s++) begin
                if (s == k && j < int'(nf_cnt_d)) begin
                    qdbg_d[j*2*DT_SZ +: 2*DT_SZ] = {nf_time_d[s], nf_num_d[s]};
                end
            end
        end
    end

    // State register; reset overrides any arrival or dispatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CNTER; i++) begin
                num_q[i] <= '0;
                rem_q[i] <= '0;
            end
            for (int s = 0; s < DEPTH; s++) begin
                nf_num_q[s]  <= '0;
                nf_time_q[s] <= '0;
            end
            for (int s = 0; s < VDEPTH; s++) begin
                vf_num_q[s]  <= '0;
                vf_time_q[s] <= '0;
            end
            nf_head_q <= '0;
            nf_cnt_q  <= '0;
            vf_head_q <= '0;
            vf_cnt_q  <= '0;
            drop_q    <= '0;
            busy_q    <= '0;
            done_q    <= '0;
            qdbg_q    <= '0;
        end else begin
            for (int i = 0; i < CNTER; i++) begin
                num_q[i] <= num_d[i];
                rem_q[i] <= rem_d[i];
            end
            for (int s = 0; s < DEPTH; s++) begin
                nf_num_q[s]  <= nf_num_d[s];
                nf_time_q[s] <= nf_time_d[s];
            end
            for (int s = 0; s < VDEPTH; s++) begin
                vf_num_q[s]  <= vf_num_d[s];
                vf_time_q[s] <= vf_time_d[s];
            end
            nf_head_q <= nf_head_d;
            nf_cnt_q  <= nf_cnt_d;
            vf_head_q <= vf_head_d;
            vf_cnt_q  <= vf_cnt_d;
            drop_q    <= drop_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            qdbg_q    <= qdbg_d;
        end
    end

    // Flatten counter registers onto the output buses.
    for (genvar g = 0; g < CNTER; g++) begin : g_bus
        assign num_bus[g*DT_SZ +: DT_SZ] = num_q[g];
        assign rem_bus[g*DT_SZ +: DT_SZ] = rem_q[g];
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign nq_cnt   = nf_cnt_q;
    assign vq_cnt   = vf_cnt_q;
    assign drop_cnt = drop_q;
    assign qdbg     = qdbg_q;

endmodule
